snes_poll_ctrl: RTL and testbench
=================================

Name: snes_poll_ctrl

Overview:
Sequences the SNES serial pad reader by issuing start requests at a programmable rate or on software demand. It captures the 12-bit button word on each completed frame, converts it to active-high and computes press/release edges. All of this is exposed to the HPS through a 32-bit Avalon-MM slave with a level interrupt. It sits between the lightweight HPS bridge and the pad reader instance.

Parameters:
POLL_DIV, 833333, clk_50 cycles between automatic polls (60 Hz at 50 MHz); legal range 16384..2^24-1.
TIMEOUT, 16383, max cycles from start request to reader finish before abort; 14-bit counter.

Ports:
clk_50  in  1  system clock, 50 MHz
reset_n  in  1  asynchronous active-low reset
avs_address  in  2  register word index
avs_read  in  1  read strobe
avs_write  in  1  write strobe
avs_writedata  in  32  write data
avs_readdata  out  32  read data, registered
irq  out  1  level interrupt to HPS
snes_start  out  1  start request to reader
snes_idle  in  1  reader idle flag
snes_finish  in  1  reader one-cycle finish pulse
snes_buttons  in  12  reader button word, active-low (0 = pressed)

Behaviour:
- Reset: all outputs 0; CTRL=0, STATUS=0, BUTTONS=0, EDGES=0; FSM in S_IDLE; poll counter loaded with POLL_DIV-1.
- Registers:
  - 0 CTRL rw: [0] enable auto-poll, [1] irq_en, [2] trigger (write-1 pulse, reads 0).
  - 1 STATUS: [0] busy (ro), [1] new_data (W1C), [2] timeout (W1C), [3] overrun (W1C).
  - 2 BUTTONS ro: [11:0] latest word, active-high.
  - 3 EDGES W1C: [11:0] pressed, [27:16] released.
  - Unused bits read 0.
- Read latency: 1 cycle; avs_readdata holds its value until the next read.
- Poll counter: decrements only while CTRL[0]=1. At 0 it reloads POLL_DIV-1 and raises a one-cycle tick. Clearing CTRL[0] reloads the counter.
- req = tick OR trigger write.
- FSM states:
  - S_IDLE: if req AND snes_idle=1, go to S_START. A req that arrives while not in S_IDLE, or while snes_idle=0, is dropped and sets overrun.
  - S_START: snes_start=1; timeout counter runs. When snes_idle=0, go to S_WAIT.
  - S_WAIT: snes_start=0. On snes_finish=1, go to S_CAPTURE.
  - S_CAPTURE (1 cycle): new = ~snes_buttons. BUTTONS<=new; pressed |= new & ~old; released |= old & ~new; new_data<=1. Return to S_IDLE.
- busy = 1 in any state other than S_IDLE.
- Timeout: counter cleared on leaving S_IDLE and increments in S_START/S_WAIT. When it reaches TIMEOUT: set timeout flag, drop snes_start, return to S_IDLE; BUTTONS and EDGES are unchanged.
- W1C vs set in the same cycle: the set wins.
- irq = CTRL[1] & (new_data | timeout), registered, so it asserts 1 cycle after the flag is set.
- Reset mid-frame: the controller returns to S_IDLE. The reader may still be mid-frame; no new start is issued until snes_idle=1.

Optional Feature:
SNES_POLL_DEBOUNCE_EN:
- Defined: BUTTONS and EDGES update only when two consecutive captured frames are identical. A differing frame is held as the candidate and sets new_data only once it is confirmed.
- Undefined: every captured frame updates BUTTONS and EDGES directly.

Test Plan:
- Write CTRL=0x1; reader model returns 0xFFE after 10800 cycles → snes_start high until idle drops; BUTTONS=0x001; EDGES=0x00000001; new_data=1.
- With irq_en=1, capture a frame → irq rises 1 cycle after new_data; write STATUS=0x2 → irq low next cycle.
- Frame 0xFFE then frame 0xFFD, with no clear between → BUTTONS=0x002; EDGES=0x00010003.
- Reader never pulses finish → timeout=1 after 16383 cycles; snes_start=0; busy=0; BUTTONS unchanged.
- Trigger write while busy → overrun=1; exactly one frame requested.
- Assert reset_n low during S_WAIT with the reader mid-frame → outputs 0 immediately; the next trigger waits for snes_idle=1 before snes_start rises.

Source files
------------

// File: rtl/snes_poll_ctrl.sv
// snes_poll_ctrl: Avalon-MM poll sequencer, button latch and edge detector for the SNES pad reader.
// Optional build macro SNES_POLL_DEBOUNCE_EN: commit a frame only after two identical captures.
module snes_poll_ctrl #(
  parameter int unsigned POLL_DIV = 833333,
  parameter int unsigned TIMEOUT  = 16383
) (
  input  logic        clk_50,
  input  logic        reset_n,
  input  logic [1:0]  avs_address,
  input  logic        avs_read,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  output logic [31:0] avs_readdata,
  output logic        irq,
  output logic        snes_start,
  input  logic        snes_idle,
  input  logic        snes_finish,
  input  logic [11:0] snes_buttons
);
  localparam logic [23:0] POLL_RELOAD = 24'(POLL_DIV - 1);
  localparam logic [13:0] TO_MAX      = 14'(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_CAPTURE} state_t;
  state_t state_q, state_d;

  logic [1:0]  ctrl_q, ctrl_d;
  logic        new_data_q, new_data_d, timeout_q, timeout_d, overrun_q, overrun_d;
  logic [11:0] buttons_q, buttons_d, pressed_q, pressed_d, released_q, released_d;
  logic [23:0] poll_cnt_q, poll_cnt_d;
  logic [13:0] to_cnt_q, to_cnt_d;
  logic        irq_q, irq_d;
  logic [31:0] rdata_q, rdata_d;
  logic        wr_ctrl, wr_status, wr_edges, tick, req, capture, commit, to_hit, ovr_set, busy;
  logic [11:0] new_btn;

  assign wr_ctrl   = avs_write && (avs_address == 2'd0);
  assign wr_status = avs_write && (avs_address == 2'd1);
  assign wr_edges  = avs_write && (avs_address == 2'd3);
  assign tick      = ctrl_q[0] && (poll_cnt_q == 24'd0);
  assign req       = tick || (wr_ctrl && avs_writedata[2]);
  assign busy      = (state_q != S_IDLE);
  assign ovr_set   = req && (busy || !snes_idle);
  assign new_btn   = ~snes_buttons;

  assign snes_start   = (state_q == S_START);
  assign irq          = irq_q;
  assign avs_readdata = rdata_q;

`ifdef SNES_POLL_DEBOUNCE_EN
  logic [11:0] cand_q, cand_d;
  logic        cand_vld_q, cand_vld_d;

  // A frame is committed only when it repeats the previously captured one.
  assign commit     = capture && cand_vld_q && (new_btn == cand_q);
  assign cand_d     = capture ? new_btn : cand_q;
  assign cand_vld_d = capture ? 1'b1 : cand_vld_q;

  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      cand_q     <= 12'd0;
      cand_vld_q <= 1'b0;
    end else begin
      cand_q     <= cand_d;
      cand_vld_q <= cand_vld_d;
    end
  end
`else
  assign commit = capture;
`endif

  always_comb begin
    poll_cnt_d = poll_cnt_q;
    if (!ctrl_q[0] || tick) poll_cnt_d = POLL_RELOAD;
    else                    poll_cnt_d = poll_cnt_q - 24'd1;
  end

  always_comb begin
    state_d  = state_q;
    to_cnt_d = to_cnt_q;
    to_hit   = 1'b0;
    capture  = 1'b0;
    case (state_q)
      S_IDLE: begin
        to_cnt_d = 14'd0;
        if (req && snes_idle) state_d = S_START;
      end
      S_START, S_WAIT: begin
        // The abort check takes priority over any reader handshake in the same cycle.
        if (to_cnt_q == TO_MAX) begin
          to_hit  = 1'b1;
          state_d = S_IDLE;
        end else begin
          to_cnt_d = to_cnt_q + 14'd1;
          if ((state_q == S_START) && !snes_idle) state_d = S_WAIT;
          if ((state_q == S_WAIT) && snes_finish) state_d = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        capture = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ctrl_d     = wr_ctrl ? avs_writedata[1:0] : ctrl_q;
    new_data_d = (new_data_q & ~(wr_status & avs_writedata[1])) | commit;
    timeout_d  = (timeout_q  & ~(wr_status & avs_writedata[2])) | to_hit;
    overrun_d  = (overrun_q  & ~(wr_status & avs_writedata[3])) | ovr_set;
    buttons_d  = commit ? new_btn : buttons_q;
    pressed_d  = (pressed_q  & ~({12{wr_edges}} & avs_writedata[11:0]))
               | ({12{commit}} & new_btn & ~buttons_q);
    released_d = (released_q & ~({12{wr_edges}} & avs_writedata[27:16]))
               | ({12{commit}} & buttons_q & ~new_btn);
    irq_d      = ctrl_q[1] & (new_data_q | timeout_q);
    rdata_d    = rdata_q;
    if (avs_read) begin
      case (avs_address)
        2'd0:    rdata_d = {30'd0, ctrl_q};
        2'd1:    rdata_d = {28'd0, overrun_q, timeout_q, new_data_q, busy};
        2'd2:    rdata_d = {20'd0, buttons_q};
        default: rdata_d = {4'd0, released_q, 4'd0, pressed_q};
      endcase
    end
  end

  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      ctrl_q     <= 2'd0;
      new_data_q <= 1'b0;
      timeout_q  <= 1'b0;
      overrun_q  <= 1'b0;
      buttons_q  <= 12'd0;
      pressed_q  <= 12'd0;
      released_q <= 12'd0;
      poll_cnt_q <= POLL_RELOAD;
      to_cnt_q   <= 14'd0;
      irq_q      <= 1'b0;
      rdata_q    <= 32'd0;
    end else begin
      state_q    <= state_d;
      ctrl_q     <= ctrl_d;
      new_data_q <= new_data_d;
      timeout_q  <= timeout_d;
      overrun_q  <= overrun_d;
      buttons_q  <= buttons_d;
      pressed_q  <= pressed_d;
      released_q <= released_d;
      poll_cnt_q <= poll_cnt_d;
      to_cnt_q   <= to_cnt_d;
      irq_q      <= irq_d;
      rdata_q    <= rdata_d;
    end
  end

endmodule

// File: tb/tb_snes_poll_ctrl.sv
// Self-checking bench for snes_poll_ctrl with a behavioural SNES reader model.
`timescale 1ns/1ps
module tb_snes_poll_ctrl;
  localparam int POLL = 16384;
  localparam int TMO  = 16383;

  logic        clk_50 = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  avs_address = 2'd0;
  logic        avs_read = 1'b0;
  logic        avs_write = 1'b0;
  logic [31:0] avs_writedata = 32'd0;
  logic [31:0] avs_readdata;
  logic        irq;
  logic        snes_start;
  logic        snes_idle = 1'b1;
  logic        snes_finish = 1'b0;
  logic [11:0] snes_buttons = 12'hFFF;

  always #10 clk_50 = ~clk_50;

  snes_poll_ctrl #(.POLL_DIV(POLL), .TIMEOUT(TMO)) dut (
    .clk_50(clk_50), .reset_n(reset_n),
    .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
    .avs_writedata(avs_writedata), .avs_readdata(avs_readdata), .irq(irq),
    .snes_start(snes_start), .snes_idle(snes_idle), .snes_finish(snes_finish),
    .snes_buttons(snes_buttons)
  );

  // Reader model: accepts a start while idle, finishes after rd_latency cycles.
  logic        rd_busy = 1'b0;
  int          rd_cnt = 0;
  int          rd_latency = 10;
  logic [11:0] rd_frame = 12'hFFF;
  logic        rd_hang = 1'b0;
  logic        rd_kill = 1'b0;
  int          rd_starts = 0;

  always @(posedge clk_50) begin
    if (rd_kill) begin
      rd_busy     <= 1'b0;
      snes_idle   <= 1'b1;
      snes_finish <= 1'b0;
    end else begin
      snes_finish <= 1'b0;
      if (!rd_busy) begin
        if (snes_start === 1'b1) begin
          rd_busy      <= 1'b1;
          snes_idle    <= 1'b0;
          rd_cnt       <= rd_latency;
          snes_buttons <= rd_frame;
          rd_starts    <= rd_starts + 1;
        end
      end else if (rd_cnt <= 1) begin
        if (!rd_hang) begin
          snes_finish <= 1'b1;
          snes_idle   <= 1'b1;
          rd_busy     <= 1'b0;
        end
      end else begin
        rd_cnt <= rd_cnt - 1;
      end
    end
  end

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick_n(input int n);
    repeat (n) @(negedge clk_50);
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk_50);
    avs_address = a; avs_writedata = d; avs_write = 1'b1;
    @(negedge clk_50);
    avs_write = 1'b0; avs_writedata = 32'd0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk_50);
    avs_address = a; avs_read = 1'b1;
    @(negedge clk_50);
    avs_read = 1'b0;
    d = avs_readdata;
  endtask

  task automatic wait_finish(input int budget, input string name);
    int n;
    n = 0;
    while (snes_finish !== 1'b1 && n < budget) begin
      @(negedge clk_50);
      n++;
    end
    check(name, {31'd0, snes_finish}, 32'd1);
  endtask

  task automatic do_frame(input logic [11:0] frame, input int lat, input logic [31:0] ctrl_bits);
    rd_frame = frame;
    rd_latency = lat;
    bus_write(2'd0, ctrl_bits | 32'h4);
    wait_finish(lat + 30, "frame_finish_seen");
    tick_n(3);
  endtask

  task automatic do_reset();
    @(negedge clk_50);
    reset_n = 1'b0;
    tick_n(2);
    reset_n = 1'b1;
    tick_n(1);
  endtask

  typedef struct {
    logic [11:0] frame;
    logic        clr;
    logic [11:0] exp_btn;
    logic [31:0] exp_edges;
  } vec_t;
  vec_t tbl [5];

  logic [31:0] rd;
  logic [31:0] clr;
  logic [11:0] frame, nb, m_btn, m_pr, m_rl;
  int          n, s0;
  logic        seen;

  initial begin
    tbl[0] = '{12'hFFE, 1'b0, 12'h001, 32'h0000_0001};
    tbl[1] = '{12'hFFD, 1'b0, 12'h002, 32'h0001_0003};
    tbl[2] = '{12'hFFF, 1'b1, 12'h000, 32'h0002_0000};
    tbl[3] = '{12'h000, 1'b1, 12'hFFF, 32'h0000_0FFF};
    tbl[4] = '{12'h5A5, 1'b0, 12'hA5A, 32'h05A5_0FFF};

    // Reset state
    tick_n(3);
    check("rst_snes_start", {31'd0, snes_start}, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    check("rst_readdata", avs_readdata, 32'd0);
    reset_n = 1'b1;
    tick_n(2);
    for (int a = 0; a < 4; a++) begin
      bus_read(2'(a), rd);
      check($sformatf("rst_reg%0d", a), rd, 32'd0);
    end
    bus_write(2'd0, 32'hFFFF_FFF2);
    bus_read(2'd0, rd);
    check("ctrl_readback", rd, 32'h2);
    bus_write(2'd0, 32'h0);

    // Table-driven frames
    for (int i = 0; i < 5; i++) begin
      if (tbl[i].clr) bus_write(2'd3, 32'hFFFF_FFFF);
      do_frame(tbl[i].frame, 40, 32'h0);
      bus_read(2'd2, rd);
      check($sformatf("tbl%0d_buttons", i), rd, {20'd0, tbl[i].exp_btn});
      bus_read(2'd3, rd);
      check($sformatf("tbl%0d_edges", i), rd, tbl[i].exp_edges);
      bus_read(2'd1, rd);
      check($sformatf("tbl%0d_status", i), rd, 32'h2);
      bus_write(2'd1, 32'h2);
    end

    // Auto-poll from a clean state
    do_reset();
    rd_frame = 12'hFFE;
    rd_latency = 10800;
    bus_write(2'd0, 32'h1);
    n = 0;
    while (snes_start !== 1'b1 && n < POLL + 20) begin
      @(negedge clk_50);
      n++;
    end
    check("poll_period", {31'd0, (n >= POLL - 4) && (n <= POLL + 4)}, 32'd1);
    n = 0;
    while (snes_start === 1'b1 && n < 10) begin
      @(negedge clk_50);
      n++;
    end
    check("start_low_after_idle_drop", {snes_start, snes_idle}, 32'd0);
    bus_write(2'd0, 32'h0);
    wait_finish(11000, "poll_finish_seen");
    tick_n(3);
    bus_read(2'd2, rd);
    check("poll_buttons", rd, 32'h001);
    bus_read(2'd3, rd);
    check("poll_edges", rd, 32'h0000_0001);
    bus_read(2'd1, rd);
    check("poll_status", rd, 32'h2);

    // Interrupt timing
    bus_write(2'd1, 32'hE);
    bus_write(2'd0, 32'h2);
    tick_n(2);
    check("irq_idle_low", {31'd0, irq}, 32'd0);
    rd_frame = 12'hFFE;
    rd_latency = 30;
    bus_write(2'd0, 32'h6);
    wait_finish(60, "irq_finish_seen");
    @(negedge clk_50);
    check("irq_low_at_capture", {31'd0, irq}, 32'd0);
    @(negedge clk_50);
    check("irq_low_flag_cycle", {31'd0, irq}, 32'd0);
    @(negedge clk_50);
    check("irq_high_after_flag", {31'd0, irq}, 32'd1);
    bus_write(2'd1, 32'h2);
    check("irq_still_high_on_clear", {31'd0, irq}, 32'd1);
    @(negedge clk_50);
    check("irq_low_after_clear", {31'd0, irq}, 32'd0);

    // Reader never finishes
    bus_write(2'd0, 32'h0);
    bus_write(2'd1, 32'hE);
    rd_hang = 1'b1;
    bus_write(2'd0, 32'h4);
    tick_n(TMO - 13);
    bus_read(2'd1, rd);
    check("timeout_not_yet", rd, 32'h1);
    tick_n(30);
    bus_read(2'd1, rd);
    check("timeout_status", rd, 32'h4);
    check("timeout_start_low", {31'd0, snes_start}, 32'd0);
    bus_read(2'd2, rd);
    check("timeout_buttons_kept", rd, 32'h001);
    @(negedge clk_50); rd_kill = 1'b1;
    @(negedge clk_50); rd_kill = 1'b0; rd_hang = 1'b0;
    bus_write(2'd1, 32'hE);

    // Trigger while busy
    s0 = rd_starts;
    rd_frame = 12'h0F0;
    rd_latency = 200;
    bus_write(2'd0, 32'h4);
    tick_n(10);
    bus_write(2'd0, 32'h4);
    wait_finish(250, "ovr_finish_seen");
    tick_n(20);
    check("ovr_one_frame", rd_starts - s0, 32'd1);
    bus_read(2'd1, rd);
    check("ovr_status", rd, 32'hA);

    // Reset during S_WAIT with the reader mid-frame
    bus_write(2'd0, 32'h2);
    tick_n(2);
    check("pre_reset_irq", {31'd0, irq}, 32'd1);
    bus_read(2'd2, rd);
    check("pre_reset_buttons", rd, 32'hF0F);
    rd_frame = 12'hAAA;
    rd_latency = 300;
    bus_write(2'd0, 32'h6);
    tick_n(20);
    reset_n = 1'b0;
    #1;
    check("midrst_outputs", {avs_readdata[29:0], irq, snes_start}, 32'd0);
    tick_n(2);
    reset_n = 1'b1;
    bus_write(2'd0, 32'h4);
    seen = 1'b0;
    for (int k = 0; k < 5; k++) begin
      seen = seen | snes_start;
      @(negedge clk_50);
    end
    check("midrst_no_start_while_busy", {31'd0, seen}, 32'd0);
    bus_read(2'd1, rd);
    check("midrst_overrun", rd, 32'h8);
    wait_finish(400, "midrst_reader_done");
    tick_n(2);
    rd_frame = 12'h5A5;
    rd_latency = 20;
    bus_write(2'd0, 32'h4);
    check("midrst_start_when_idle", {31'd0, snes_start}, 32'd1);
    wait_finish(50, "midrst_finish_seen");
    tick_n(3);
    bus_read(2'd2, rd);
    check("midrst_buttons", rd, 32'hA5A);

    // Randomized frames against the reference model
    do_reset();
    m_btn = 12'd0; m_pr = 12'd0; m_rl = 12'd0;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        clr = $urandom;
        bus_write(2'd3, clr);
        m_pr = m_pr & ~clr[11:0];
        m_rl = m_rl & ~clr[27:16];
      end
      frame = 12'($urandom_range(0, 4095));
      nb = ~frame;
      m_pr = m_pr | (nb & ~m_btn);
      m_rl = m_rl | (m_btn & ~nb);
      m_btn = nb;
      do_frame(frame, $urandom_range(3, 30), 32'h0);
      bus_read(2'd2, rd);
      check($sformatf("rnd%0d_buttons", i), rd, {20'd0, m_btn});
      bus_read(2'd3, rd);
      check($sformatf("rnd%0d_edges", i), rd, {4'd0, m_rl, 4'd0, m_pr});
      bus_read(2'd1, rd);
      check($sformatf("rnd%0d_new_data", i), {31'd0, rd[1]}, 32'd1);
      bus_write(2'd1, 32'h2);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
